prime_gap_buffer: RTL

Downstream consumer of the prime number generator. It watches the generator's held `prime_number` output and detects each new prime value. For each new prime it computes the gap to the previous prime and flags twin primes. Each result is queued in a small FIFO and drained by the next stage over a valid/ready handshake, so bursts of primes are not lost when that stage stalls.

---
 rtl/prime_pkg.sv | 17 +
 rtl/prime_sync_fifo.sv | 67 ++++++
 rtl/prime_gap_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/prime_pkg.sv
// Shared types for the prime generator datapath.
// FIFO word layout and gap field limits.
package prime_pkg;

  localparam int PRIME_W     = 32;
  localparam int PRIME_GAP_W = 16;

  localparam logic [PRIME_GAP_W-1:0] PRIME_GAP_MAX = '1;

  typedef struct packed {
    logic [PRIME_W-1:0]     prime;
    logic [PRIME_GAP_W-1:0] gap;
    logic                   twin;
    logic                   restart;
  } prime_entry_t;

endpackage

// File: rtl/prime_sync_fifo.sv
// Single-clock first-word-fall-through FIFO of prime entries.
// Count-based full/empty; push while full is accepted only with a pop.
module prime_sync_fifo
  import prime_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  prime_entry_t wdata,
  input  logic         pop,
  output prime_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  prime_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = pop && !w_empty;
  assign w_push  = push && (!w_full || w_pop);

  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;
  assign rdata = w_empty ? '0 : r_mem[r_rd];

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  // Storage array; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr] <= wdata;
  end

endmodule

// File: rtl/prime_gap_buffer.sv
// Detects new primes from the generator, computes gap/twin/restart,
// and queues results for a valid/ready consumer.
module prime_gap_buffer
  import prime_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int GAP_W  = 16,
  parameter int DEPTH  = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] prime_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_prime,
  output logic [GAP_W-1:0]  out_gap,
  output logic              out_twin,
  output logic              out_restart,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  localparam logic [GAP_W-1:0]  GAP_SAT = '1;
  localparam logic [DATA_W-1:0] GAP_CAP = DATA_W'(GAP_SAT);

  logic [DATA_W-1:0] r_last;
  logic              r_overflow;

  logic              w_event;
  logic              w_restart;
  logic [DATA_W-1:0] w_diff;
  logic [GAP_W-1:0]  w_gap;
  logic              w_twin;
  prime_entry_t      w_entry;
  prime_entry_t      w_head;
  logic              w_full;
  logic              w_empty;

  assign w_event = !clear
                && (prime_in != '0)
                && (prime_in != r_last);

  assign w_restart = (r_last != '0)
                  && (prime_in < r_last);

  assign w_diff = prime_in - r_last;

  // Gap is zero for the first prime or a restart, else saturated diff.
  always_comb begin
    w_gap = '0;
    if ((r_last != '0) && !w_restart) begin
      if (w_diff > GAP_CAP) w_gap = GAP_SAT;
      else                  w_gap = w_diff[GAP_W-1:0];
    end
  end

  assign w_twin = (w_gap == GAP_W'(2));

  // Pack the new-prime result into the shared FIFO word.
  always_comb begin
    w_entry         = '0;
    w_entry.prime   = PRIME_W'(prime_in);
    w_entry.gap     = PRIME_GAP_W'(w_gap);
    w_entry.twin    = w_twin;
    w_entry.restart = w_restart;
  end

  prime_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (clear),
    .push  (w_event),
    .wdata (w_entry),
    .pop   (out_ready),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  assign out_valid   = !w_empty;
  assign out_prime   = w_head.prime[DATA_W-1:0];
  assign out_gap     = w_head.gap[GAP_W-1:0];
  assign out_twin    = w_head.twin;
  assign out_restart = w_head.restart;
  assign overflow    = r_overflow;

  // Track the last prime seen, even when its entry is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_last <= '0;
    else if (clear)   r_last <= '0;
    else if (w_event) r_last <= prime_in;
  end

  // Sticky drop flag: event while full with no pop to make room.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_overflow <= 1'b0;
    else if (clear)
      r_overflow <= 1'b0;
    else if (w_event && w_full && !out_ready)
      r_overflow <= 1'b1;
  end

endmodule
